encoder_4to2: RTL and testbench
===============================

ENCODER_4TO2 -- requirements
Module: encoder_4to2

Interface
REQ-001 Parameter: PRIORITY_HIGH, default 1, selects priority direction: 1 = highest set bit wins, 0 = lowest set bit wins.
REQ-002 clk  input  1  rising-edge clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  sample enable; registers update only when en=1.
REQ-005 in  input  4  request vector, bit i = request i.
REQ-006 out  output  2  registered binary index of the winning request bit.
REQ-007 valid  output  1  registered; 1 when the sampled in had at least one bit set.
REQ-008 multi  output  1  registered; 1 when the sampled in had two or more bits set.

Function
REQ-009 The block SHALL be fully synchronous: out, valid and multi SHALL be driven only from registers clocked by clk.
REQ-010 Latency SHALL be one cycle: the value of in sampled at rising edge N with en=1 SHALL appear on out/valid/multi immediately after edge N.
REQ-011 One-hot encoding SHALL be: 0001->00, 0010->01, 0100->10, 1000->11, each with valid=1 and multi=0.
REQ-012 For in=0000, the block SHALL register out=00, valid=0, multi=0.
REQ-013 For multi-hot in with PRIORITY_HIGH=1, out SHALL be the index of the highest set bit, with valid=1 and multi=1.
REQ-014 For multi-hot in with PRIORITY_HIGH=0, out SHALL be the index of the lowest set bit, with valid=1 and multi=1.
REQ-015 multi SHALL be 1 exactly when popcount(in) >= 2, independent of PRIORITY_HIGH.
REQ-016 When en=0 and rst=0, out, valid and multi SHALL hold their previous values; in SHALL be ignored.
REQ-017 All 16 input values SHALL produce a defined output; the outputs SHALL never be X or Z after the first reset.
REQ-018 A change on in between clock edges SHALL have no effect on the outputs until the next enabled edge.
REQ-019 When in is unchanged and en=1 on consecutive edges, the outputs SHALL remain stable with no glitch.

Reset
REQ-020 When rst=1 at a rising edge, out SHALL become 00, valid 0 and multi 0 after that edge.
REQ-021 rst SHALL take priority over en and in at the same edge.
REQ-022 Asserting rst mid-operation SHALL clear the outputs at the next edge; the first enabled edge after rst deasserts SHALL load normally.
REQ-023 Before the first reset edge, the output values are unspecified.

Verification
REQ-024 Reset check: rst=1 for 2 cycles with en=1 and in=1111 -> out=00, valid=0, multi=0.
REQ-025 One-hot sweep: en=1, apply in=0001, 0010, 0100, 1000 on successive edges -> one cycle later out=00, 01, 10, 11, with valid=1 and multi=0 for each.
REQ-026 Zero/multi-hot check (PRIORITY_HIGH=1): in=0000 -> out=00, valid=0, multi=0; in=0110 -> out=10, valid=1, multi=1; in=1111 -> out=11, multi=1. With PRIORITY_HIGH=0, in=0110 -> out=01.
REQ-027 Enable hold: load in=0100 with en=1 (out=10), then drop en to 0 and apply in=0001 for 3 cycles -> out stays 10 and valid stays 1.
REQ-028 Random: 10 uniformly random values 0..15 at 10-time-unit spacing, en=1 -> every output matches a reference priority model, delayed by one cycle.
REQ-029 Mid-run reset: assert rst for one edge while in=1000 and en=1 -> outputs clear; release rst -> next edge gives out=11, valid=1.

Source files
------------

// File: rtl/encoder_4to2_if.sv
// encoder_4to2_if: request/result bundle for the 4-to-2 priority encoder.
//   en    - sample enable (master -> slave)
//   in    - 4-bit request vector (master -> slave)
//   out   - registered winning index (slave -> master)
//   valid - registered "any request" flag (slave -> master)
//   multi - registered "two or more requests" flag (slave -> master)
interface encoder_4to2_if;
    logic       en;
    logic [3:0] in;
    logic [1:0] out;
    logic       valid;
    logic       multi;
    modport master (output en, in, input out, valid, multi);
    modport slave (input en, in, output out, valid, multi);
endinterface

// File: rtl/encoder_4to2.sv
// encoder_4to2: registered 4-to-2 priority encoder with valid and multi-hot flags.
//   clk - rising-edge clock
//   rst - synchronous active-high reset, clears out/valid/multi
//   bus - encoder_4to2_if slave: en/in sampled, out/valid/multi registered
//   PRIORITY_HIGH - 1: highest set bit wins, 0: lowest set bit wins
module encoder_4to2 #(
    parameter int PRIORITY_HIGH = 1
) (
    input logic           clk,
    input logic           rst,
    encoder_4to2_if.slave bus
);
    logic [1:0] idx;
    logic       many;
    // An all-zero request falls through both chains to index 0.
    always_comb begin
        idx = (PRIORITY_HIGH != 0)
            ? (bus.in[3] ? 2'd3 : bus.in[2] ? 2'd2 : bus.in[1] ? 2'd1 : 2'd0)
            : (bus.in[0] ? 2'd0 : bus.in[1] ? 2'd1 : bus.in[2] ? 2'd2 : bus.in[3] ? 2'd3 : 2'd0);
        many = $countones(bus.in) > 1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out   <= 2'd0;
            bus.valid <= 1'b0;
            bus.multi <= 1'b0;
        end else if (bus.en) begin
            bus.out   <= idx;
            bus.valid <= |bus.in;
            bus.multi <= many;
        end
    end
endmodule

// File: tb/tb_encoder_4to2.sv
// tb_encoder_4to2: drives both priority variants with directed and random stimulus against a reference model.
module tb_encoder_4to2;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] in = 4'd0;
    int         errors = 0;
    int         checks = 0;

    encoder_4to2_if ih ();
    encoder_4to2_if il ();
    assign ih.en = en;
    assign ih.in = in;
    assign il.en = en;
    assign il.in = in;

    encoder_4to2 #(.PRIORITY_HIGH(1)) dut_h (.clk(clk), .rst(rst), .bus(ih));
    encoder_4to2 #(.PRIORITY_HIGH(0)) dut_l (.clk(clk), .rst(rst), .bus(il));

    always #5 clk = ~clk;

    function automatic logic [1:0] winner(logic [3:0] v, bit high);
        logic [1:0] r = 2'd0;
        bit found = 0;
        for (int i = 0; i < 4; i++)
            if (v[i]) begin
                if (high || !found) r = 2'(i);
                found = 1;
            end
        return r;
    endfunction

    function automatic int popcount(logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    logic [1:0] m_out_h, m_out_l;
    logic       m_valid, m_multi;
    bit         armed = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_out_h <= 2'd0;
            m_out_l <= 2'd0;
            m_valid <= 1'b0;
            m_multi <= 1'b0;
            armed   <= 1;
        end else if (en) begin
            m_out_h <= winner(in, 1);
            m_out_l <= winner(in, 0);
            m_valid <= in != 4'd0;
            m_multi <= popcount(in) >= 2;
        end
    end

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk)
        if (armed) begin
            chk("model out_h", {2'b0, ih.out}, {2'b0, m_out_h});
            chk("model out_l", {2'b0, il.out}, {2'b0, m_out_l});
            chk("model valid_h", {3'b0, ih.valid}, {3'b0, m_valid});
            chk("model valid_l", {3'b0, il.valid}, {3'b0, m_valid});
            chk("model multi_h", {3'b0, ih.multi}, {3'b0, m_multi});
            chk("model multi_l", {3'b0, il.multi}, {3'b0, m_multi});
        end

    // Inputs get a junk value first, then the real one, so mid-cycle changes must not leak through.
    task automatic step(logic r, logic e, logic [3:0] v);
        rst = r;
        en  = e;
        in  = 4'($urandom_range(0, 15));
        #2;
        in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string name, logic [1:0] oh, logic [1:0] ol, logic v, logic m);
        chk({name, " out_h"}, {2'b0, ih.out}, {2'b0, oh});
        chk({name, " out_l"}, {2'b0, il.out}, {2'b0, ol});
        chk({name, " valid"}, {3'b0, ih.valid}, {3'b0, v});
        chk({name, " multi"}, {3'b0, ih.multi}, {3'b0, m});
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1, 1, 4'b1111);
        step(1, 1, 4'b1111);
        lit("reset", 2'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 4'(1 << k));
            lit("onehot", 2'(k), 2'(k), 1'b1, 1'b0);
        end
        step(0, 1, 4'b0000);
        lit("zero", 2'd0, 2'd0, 1'b0, 1'b0);
        step(0, 1, 4'b0110);
        lit("0110", 2'd2, 2'd1, 1'b1, 1'b1);
        step(0, 1, 4'b1111);
        lit("1111", 2'd3, 2'd0, 1'b1, 1'b1);
        step(0, 1, 4'b0100);
        lit("hold load", 2'd2, 2'd2, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 4'b0001);
            lit("hold", 2'd2, 2'd2, 1'b1, 1'b0);
        end
        for (int k = 0; k < 10; k++) step(0, 1, 4'($urandom_range(0, 15)));
        step(0, 1, 4'b0001);
        step(1, 1, 4'b1000);
        lit("midrst", 2'd0, 2'd0, 1'b0, 1'b0);
        step(0, 1, 4'b1000);
        lit("post rst", 2'd3, 2'd3, 1'b1, 1'b0);
        step(0, 1, 4'b1010);
        step(0, 1, 4'b1010);
        lit("repeat", 2'd3, 2'd1, 1'b1, 1'b1);
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
